i2c_target: RTL and testbench

- I2C target (slave) endpoint: the responder for the team's I2C master on the same two-wire bus.
- Exposes a small byte-wide register file to the bus. Bus writes set a register pointer and then store data. Bus reads return data from the pointer.
- Sits beside the master in the FPGA top level, or on a second board. Runs from the system clock and oversamples SCL/SDA.
- No clock stretching: the target never drives SCL.

---
 rtl/i2c_target_if.sv | 15 +
 rtl/i2c_target.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// Register-file side of the I2C target: stored bytes, write notification and
// transfer-in-progress flag, driven by the target and consumed by user logic.
interface i2c_target_if #(
    parameter int NrOfRegisters = 16
);
    localparam int IndexWidth = (NrOfRegisters > 1) ? $clog2(NrOfRegisters) : 1;

    logic [NrOfRegisters-1:0][7:0] registers;
    logic                          writeStrobe;
    logic [IndexWidth-1:0]         writeIndex;
    logic                          busy;

    modport master (output registers, writeStrobe, writeIndex, busy);
    modport slave  (input  registers, writeStrobe, writeIndex, busy);
endinterface

// File: rtl/i2c_target.sv
// I2C target endpoint: oversamples SCL/SDA, answers one 7-bit address and
// exposes a byte register file with an auto-incrementing pointer.
module i2c_target #(
    parameter logic [6:0] Address       = 7'h50,
    parameter int         NrOfRegisters = 16,
    parameter int         SyncStages    = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         scl,
    inout  wire          sda,
    i2c_target_if.master regs_if
);
    localparam int PW = (NrOfRegisters > 1) ? $clog2(NrOfRegisters) : 1;
    localparam logic [PW-1:0] LastIndex = PW'(NrOfRegisters - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_PTR, RX_DATA, RX_ACK, TX_BYTE, TX_ACK
    } state_e;

    state_e                        state_q, state_d;
    logic [SyncStages-1:0]         scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                          scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [3:0]                    bit_cnt_q, bit_cnt_d;
    logic [7:0]                    shift_q, shift_d;
    logic                          rw_q, rw_d;
    logic [PW-1:0]                 ptr_q, ptr_d;
    logic                          sda_oe_q, sda_oe_d;
    logic                          busy_q, busy_d;
    logic                          write_strobe_q, write_strobe_d;
    logic [PW-1:0]                 write_index_q, write_index_d;
    logic [NrOfRegisters-1:0][7:0] regs_q, regs_d;

    logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, byte_done_s;
    logic [7:0] tx_byte_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastIndex) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign scl_s       = scl_sync_q[SyncStages-1];
    assign sda_s       = sda_sync_q[SyncStages-1];
    assign scl_rise_s  = scl_s & ~scl_prev_q;
    assign scl_fall_s  = ~scl_s & scl_prev_q;
    assign start_s     = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_s      = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_done_s = (bit_cnt_q == 4'd8);
    assign tx_byte_s   = regs_q[ptr_q];

    // Open-drain: the only values ever put on the wire are 0 and high-impedance.
    assign sda = sda_oe_q ? 1'b0 : 1'bz;

    assign regs_if.registers   = regs_q;
    assign regs_if.writeStrobe = write_strobe_q;
    assign regs_if.writeIndex  = write_index_q;
    assign regs_if.busy        = busy_q;

    // Synchronizer chains and one-cycle history for edge detection
    always_comb begin
        scl_sync_d = {scl_sync_q[SyncStages-2:0], scl};
        sda_sync_d = {sda_sync_q[SyncStages-2:0], sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Protocol FSM: bits are sampled on SCL rise, SDA drive only moves on SCL fall
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        rw_d           = rw_q;
        ptr_d          = ptr_q;
        sda_oe_d       = sda_oe_q;
        busy_d         = busy_q;
        write_strobe_d = 1'b0;
        write_index_d  = write_index_q;
        regs_d         = regs_q;
        case (state_q)
            IDLE: state_d = IDLE;
            ADDR, RX_PTR, RX_DATA: begin
                if (scl_rise_s) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall_s && byte_done_s) begin
                    case (state_q)
                        ADDR: begin
                            if (shift_q[7:1] == Address) begin
                                state_d  = ADDR_ACK;
                                rw_d     = shift_q[0];
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                        RX_PTR: begin
                            if ({1'b0, shift_q} < 9'(NrOfRegisters)) begin
                                ptr_d    = PW'(shift_q);
                                sda_oe_d = 1'b1;
                                state_d  = RX_ACK;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                        default: begin
                            regs_d[ptr_q]  = shift_q;
                            write_strobe_d = 1'b1;
                            write_index_d  = ptr_q;
                            ptr_d          = ptr_inc(ptr_q);
                            sda_oe_d       = 1'b1;
                            state_d        = RX_ACK;
                        end
                    endcase
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ADDR_ACK, TX_ACK: begin
                if (state_q == TX_ACK && scl_rise_s) begin
                    if (!sda_s) begin
                        ptr_d = ptr_inc(ptr_q);
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (scl_fall_s && (state_q == TX_ACK || rw_q)) begin
                    // Bit 7 of the outgoing byte goes out on the same fall that ends the ACK slot
                    shift_d   = tx_byte_s;
                    sda_oe_d  = ~tx_byte_s[7];
                    bit_cnt_d = 4'd1;
                    state_d   = TX_BYTE;
                end else if (scl_fall_s) begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = RX_PTR;
                end else begin
                    state_d = state_q;
                end
            end
            RX_ACK: begin
                if (scl_fall_s) begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = RX_DATA;
                end else begin
                    state_d = RX_ACK;
                end
            end
            TX_BYTE: begin
                if (scl_fall_s && byte_done_s) begin
                    sda_oe_d = 1'b0;
                    state_d  = TX_ACK;
                end else if (scl_fall_s) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    sda_oe_d  = ~shift_q[6];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else begin
                    state_d = TX_BYTE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_s) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_s) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            rw_d = rw_d;
        end
    end

    // State registers; synchronizers reset to the idle-bus level to avoid false edges
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            scl_sync_q     <= {SyncStages{1'b1}};
            sda_sync_q     <= {SyncStages{1'b1}};
            scl_prev_q     <= 1'b1;
            sda_prev_q     <= 1'b1;
            bit_cnt_q      <= 4'd0;
            shift_q        <= 8'h00;
            rw_q           <= 1'b0;
            ptr_q          <= {PW{1'b0}};
            sda_oe_q       <= 1'b0;
            busy_q         <= 1'b0;
            write_strobe_q <= 1'b0;
            write_index_q  <= {PW{1'b0}};
            regs_q         <= '0;
        end else begin
            state_q        <= state_d;
            scl_sync_q     <= scl_sync_d;
            sda_sync_q     <= sda_sync_d;
            scl_prev_q     <= scl_prev_d;
            sda_prev_q     <= sda_prev_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rw_q           <= rw_d;
            ptr_q          <= ptr_d;
            sda_oe_q       <= sda_oe_d;
            busy_q         <= busy_d;
            write_strobe_q <= write_strobe_d;
            write_index_q  <= write_index_d;
            regs_q         <= regs_d;
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master driving i2c_target, checked against a transaction-level
// model of the register file and pointer.
module tb_i2c_target;
    localparam int N = 16;
    localparam int Q = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic scl = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_if #(.NrOfRegisters(N)) rif ();

    i2c_target #(.Address(7'h50), .NrOfRegisters(N), .SyncStages(2)) dut (
        .clock  (clock),
        .reset  (reset),
        .scl    (scl),
        .sda    (sda),
        .regs_if(rif)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_regs [N];
    int         model_ptr;
    int         strobe_log [$];
    logic       ack_q [$];
    logic       exp_ack_q [$];
    int         exp_idx_q [$];
    logic [7:0] rd_q [$];
    logic [7:0] exp_rd_q [$];
    logic [7:0] wd [8];
    int         wn;
    logic       busy_after_addr, sda_after_nack, busy_after_nack;

    always @(negedge clock) begin
        if (rif.writeStrobe) strobe_log.push_back(int'(rif.writeIndex));
    end

    task automatic qw;
        repeat (Q) @(posedge clock);
        #1;
    endtask

    task automatic bus_start;
        sda_low = 1'b0; qw;
        scl = 1'b1;     qw;
        sda_low = 1'b1; qw;
        scl = 1'b0;     qw;
    endtask

    task automatic bus_stop;
        sda_low = 1'b1; qw;
        scl = 1'b1;     qw;
        sda_low = 1'b0; qw;
        qw;
    endtask

    task automatic bus_bit_w(input logic b);
        sda_low = ~b; qw;
        scl = 1'b1;   qw;
        scl = 1'b0;   qw;
    endtask

    task automatic bus_bit_r(output logic b);
        sda_low = 1'b0; qw;
        scl = 1'b1;     qw;
        b = sda;
        scl = 1'b0;     qw;
    endtask

    task automatic bus_write_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bus_bit_w(v[i]);
        bus_bit_r(b);
        ack = ~b;
    endtask

    task automatic bus_read_byte(input logic mack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bus_bit_r(b);
            v[i] = b;
        end
        bus_bit_w(~mack);
    endtask

    // Master: address, pointer, then wd[0..wn-1]; stops early on any NACK.
    task automatic write_txn(input logic [7:0] addr_byte, input logic [7:0] ptr);
        logic a;
        ack_q.delete();
        bus_start;
        bus_write_byte(addr_byte, a);
        ack_q.push_back(a);
        busy_after_addr = rif.busy;
        if (a) begin
            bus_write_byte(ptr, a);
            ack_q.push_back(a);
            for (int k = 0; k < wn && a; k++) begin
                bus_write_byte(wd[k], a);
                ack_q.push_back(a);
            end
        end
        bus_stop;
    endtask

    // Master: optional pointer write + repeated START, then n reads (last one NACKed).
    task automatic read_txn(input int ptr, input int n);
        logic a;
        logic [7:0] d;
        ack_q.delete();
        rd_q.delete();
        bus_start;
        if (ptr >= 0) begin
            bus_write_byte(8'hA0, a);
            ack_q.push_back(a);
            bus_write_byte(8'(ptr), a);
            ack_q.push_back(a);
            bus_start;
        end
        bus_write_byte(8'hA1, a);
        ack_q.push_back(a);
        for (int k = 0; k < n; k++) begin
            bus_read_byte(k != n - 1, d);
            rd_q.push_back(d);
        end
        qw;
        sda_after_nack  = sda;
        busy_after_nack = rif.busy;
        bus_stop;
    endtask

    // Reference: what a compliant target answers and stores for a write transaction.
    task automatic model_write(input logic [7:0] addr_byte, input int ptr);
        exp_ack_q.delete();
        exp_idx_q.delete();
        if (addr_byte[7:1] != 7'h50) begin
            exp_ack_q.push_back(1'b0);
            return;
        end
        exp_ack_q.push_back(1'b1);
        if (ptr >= N) begin
            exp_ack_q.push_back(1'b0);
            return;
        end
        exp_ack_q.push_back(1'b1);
        model_ptr = ptr;
        for (int k = 0; k < wn; k++) begin
            model_regs[model_ptr] = wd[k];
            exp_idx_q.push_back(model_ptr);
            model_ptr = (model_ptr + 1) % N;
            exp_ack_q.push_back(1'b1);
        end
    endtask

    task automatic model_read(input int ptr, input int n);
        exp_rd_q.delete();
        if (ptr >= 0) model_ptr = ptr;
        for (int k = 0; k < n; k++) begin
            exp_rd_q.push_back(model_regs[model_ptr]);
            if (k != n - 1) model_ptr = (model_ptr + 1) % N;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        checks++;
        if (rif.busy !== 1'b0 || rif.writeStrobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b strobe=%b required 0/0", rif.busy, rif.writeStrobe);
        end
        checks++;
        if (sda !== 1'b1) begin
            errors++;
            $display("FAIL reset_sda: sda=%b required released (1)", sda);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rif.registers[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg[%0d]: got %02h required 00", i, rif.registers[i]);
            end
        end
        reset = 1'b1;
        qw;
    endtask

    task automatic test_write_burst;
        wn = 2; wd[0] = 8'h11; wd[1] = 8'h22;
        strobe_log.delete();
        model_write(8'hA0, 3);
        write_txn(8'hA0, 8'h03);
        checks++;
        if (ack_q.size() != 4 || ack_q != exp_ack_q) begin
            errors++;
            $display("FAIL burst_acks: got %0d acks %p required %p", ack_q.size(), ack_q, exp_ack_q);
        end
        checks++;
        if (busy_after_addr !== 1'b1) begin
            errors++;
            $display("FAIL burst_busy_high: got %b required 1", busy_after_addr);
        end
        checks++;
        if (rif.busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_busy_stop: got %b required 0", rif.busy);
        end
        checks++;
        if (strobe_log.size() != 2 || strobe_log[0] != 3 || strobe_log[1] != 4) begin
            errors++;
            $display("FAIL burst_strobes: got %p required 3,4", strobe_log);
        end
        checks++;
        if (rif.registers[3] !== 8'h11 || rif.registers[4] !== 8'h22) begin
            errors++;
            $display("FAIL burst_regs: got %02h %02h required 11 22", rif.registers[3], rif.registers[4]);
        end
    endtask

    task automatic test_combined_read;
        model_read(3, 2);
        read_txn(3, 2);
        checks++;
        if (ack_q.size() != 3 || ack_q[0] !== 1'b1 || ack_q[1] !== 1'b1 || ack_q[2] !== 1'b1) begin
            errors++;
            $display("FAIL read_acks: got %p required three ACKs", ack_q);
        end
        checks++;
        if (rd_q.size() != 2 || rd_q[0] !== 8'h11 || rd_q[1] !== 8'h22 || rd_q != exp_rd_q) begin
            errors++;
            $display("FAIL read_data: got %p required 11,22", rd_q);
        end
        checks++;
        if (sda_after_nack !== 1'b1 || busy_after_nack !== 1'b0) begin
            errors++;
            $display("FAIL read_release: sda=%b busy=%b required 1/0", sda_after_nack, busy_after_nack);
        end
    endtask

    task automatic test_wrong_address;
        logic [7:0] addrs [2];
        addrs[0] = 8'hA2;
        addrs[1] = 8'h00;
        for (int t = 0; t < 2; t++) begin
            wn = 1; wd[0] = 8'($urandom);
            strobe_log.delete();
            model_write(addrs[t], 1);
            write_txn(addrs[t], 8'h01);
            checks++;
            if (ack_q.size() != 1 || ack_q[0] !== exp_ack_q[0] || busy_after_addr !== 1'b0) begin
                errors++;
                $display("FAIL wrong_addr_%02h: acks %p busy=%b required NACK, busy 0", addrs[t], ack_q, busy_after_addr);
            end
            checks++;
            if (strobe_log.size() != 0 || rif.registers[1] !== model_regs[1]) begin
                errors++;
                $display("FAIL wrong_addr_nowrite_%02h: strobes %0d reg1=%02h required 0 / %02h", addrs[t], strobe_log.size(), rif.registers[1], model_regs[1]);
            end
        end
    endtask

    task automatic test_wrap_invalid;
        wn = 2; wd[0] = 8'hAA; wd[1] = 8'hBB;
        strobe_log.delete();
        model_write(8'hA0, 15);
        write_txn(8'hA0, 8'h0F);
        checks++;
        if (ack_q != exp_ack_q || strobe_log.size() != 2 || strobe_log[0] != 15 || strobe_log[1] != 0) begin
            errors++;
            $display("FAIL wrap_txn: acks %p strobes %p required %p / 15,0", ack_q, strobe_log, exp_ack_q);
        end
        checks++;
        if (rif.registers[15] !== 8'hAA || rif.registers[0] !== 8'hBB) begin
            errors++;
            $display("FAIL wrap_regs: got %02h %02h required AA BB", rif.registers[15], rif.registers[0]);
        end
        wn = 1; wd[0] = 8'h5C;
        strobe_log.delete();
        model_write(8'hA0, 16);
        write_txn(8'hA0, 8'h10);
        checks++;
        if (ack_q.size() != 2 || ack_q[1] !== 1'b0 || strobe_log.size() != 0) begin
            errors++;
            $display("FAIL bad_ptr: acks %p strobes %0d required ACK,NACK and no write", ack_q, strobe_log.size());
        end
        model_read(-1, 1);
        read_txn(-1, 1);
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== exp_rd_q[0]) begin
            errors++;
            $display("FAIL bad_ptr_kept: got %p required %02h", rd_q, exp_rd_q[0]);
        end
    endtask

    task automatic test_stop_mid_byte;
        logic a0, a1;
        strobe_log.delete();
        model_ptr = 5;
        bus_start;
        bus_write_byte(8'hA0, a0);
        bus_write_byte(8'h05, a1);
        for (int i = 0; i < 4; i++) bus_bit_w(1'($urandom));
        bus_stop;
        checks++;
        if (a0 !== 1'b1 || a1 !== 1'b1 || strobe_log.size() != 0 || rif.busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_mid: acks %b%b strobes %0d busy %b required 11/0/0", a0, a1, strobe_log.size(), rif.busy);
        end
        checks++;
        if (rif.registers[5] !== model_regs[5]) begin
            errors++;
            $display("FAIL stop_mid_reg5: got %02h required %02h", rif.registers[5], model_regs[5]);
        end
        model_read(-1, 1);
        read_txn(-1, 1);
        checks++;
        if (ack_q[0] !== 1'b1 || rd_q[0] !== exp_rd_q[0]) begin
            errors++;
            $display("FAIL stop_mid_after: ack %b data %02h required 1 / %02h", ack_q[0], rd_q[0], exp_rd_q[0]);
        end
    endtask

    task automatic test_reset_mid_read;
        logic a;
        wn = 1; wd[0] = 8'($urandom_range(0, 127));
        model_write(8'hA0, 2);
        write_txn(8'hA0, 8'h02);
        bus_start;
        bus_write_byte(8'hA0, a);
        bus_write_byte(8'h02, a);
        bus_start;
        bus_write_byte(8'hA1, a);
        checks++;
        if (a !== 1'b1 || sda !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drive: ack %b sda %b required 1 / 0 (bit7 of %02h)", a, sda, wd[0]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (sda !== 1'b1 || rif.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: sda %b busy %b required 1 / 0", sda, rif.busy);
        end
        for (int i = 0; i < N; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rif.registers[i] !== 8'h00) begin
                errors++;
                $display("FAIL rst_mid_reg[%0d]: got %02h required 00", i, rif.registers[i]);
            end
        end
        qw;
        reset = 1'b1;
        qw;
        bus_stop;
        wn = 2; wd[0] = 8'($urandom); wd[1] = 8'($urandom);
        model_write(8'hA0, 7);
        write_txn(8'hA0, 8'h07);
        model_read(7, 2);
        read_txn(7, 2);
        checks++;
        if (rd_q != exp_rd_q) begin
            errors++;
            $display("FAIL rst_mid_after: got %p required %p", rd_q, exp_rd_q);
        end
    endtask

    task automatic test_back_to_back;
        int p, n;
        for (int t = 0; t < 10; t++) begin
            p  = int'($urandom_range(0, 19));
            wn = int'($urandom_range(1, 4));
            for (int k = 0; k < wn; k++) wd[k] = 8'($urandom);
            strobe_log.delete();
            model_write(8'hA0, p);
            write_txn(8'hA0, 8'(p));
            checks++;
            if (ack_q != exp_ack_q) begin
                errors++;
                $display("FAIL b2b_acks[%0d] ptr %0d: got %p required %p", t, p, ack_q, exp_ack_q);
            end
            checks++;
            if (strobe_log != exp_idx_q) begin
                errors++;
                $display("FAIL b2b_strobes[%0d]: got %p required %p", t, strobe_log, exp_idx_q);
            end
            p = int'($urandom_range(0, N - 1));
            n = int'($urandom_range(1, 3));
            model_read(p, n);
            read_txn(p, n);
            checks++;
            if (rd_q != exp_rd_q) begin
                errors++;
                $display("FAIL b2b_read[%0d] ptr %0d: got %p required %p", t, p, rd_q, exp_rd_q);
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rif.registers[i] !== model_regs[i]) begin
                errors++;
                $display("FAIL b2b_reg[%0d]: got %02h required %02h", i, rif.registers[i], model_regs[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_burst;
        test_combined_read;
        test_wrong_address;
        test_wrap_invalid;
        test_stop_mid_byte;
        test_reset_mid_read;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
